// File: rtl/frame_draw_controller.sv
// Frame draw sequencer: on each accepted Tick, sweeps the vertically scrolled
// background into the VGA write port, then overlays the 8x8 car sprite at a
// position latched at frame start. Both ROMs have one cycle of read latency,
// so a single pipeline stage carries pixel position and source alongside.
module frame_draw_controller #(
    parameter int unsigned H_RES       = 160,
    parameter int unsigned V_RES       = 120,
    parameter int unsigned SPR_LOG2    = 3,
    parameter logic [2:0]  TRANSPARENT = 3'b101
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Tick,
    input  logic                    ScrollEn,
    input  logic [7:0]              CarX,
    input  logic [6:0]              CarY,
    output logic [14:0]             BgAddr,
    input  logic [2:0]              BgData,
    output logic [2*SPR_LOG2-1:0]   SprAddr,
    input  logic [2:0]              SprData,
    output logic [7:0]              VgaX,
    output logic [6:0]              VgaY,
    output logic [2:0]              VgaColour,
    output logic                    VgaPlot,
    output logic                    Busy,
    output logic                    FrameDone,
    output logic                    Overrun,
    output logic [6:0]              ScrollY
);

    localparam logic [7:0]          XLast   = 8'(H_RES - 1);
    localparam logic [6:0]          YLast   = 7'(V_RES - 1);
    localparam logic [7:0]          XClamp  = 8'(H_RES - (1 << SPR_LOG2));
    localparam logic [6:0]          YClamp  = 7'(V_RES - (1 << SPR_LOG2));
    localparam logic [SPR_LOG2-1:0] SprLast = '1;

    typedef enum logic [1:0] {StIdle, StBg, StCar, StFlush} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cx_q, cx_d;
    logic [6:0]            cy_q, cy_d;
    logic [SPR_LOG2-1:0]   sx_q, sx_d, sy_s_q, sy_s_d;
    logic [7:0]            car_x_q, car_x_d;
    logic [6:0]            car_y_q, car_y_d;
    logic [6:0]            scroll_q, scroll_d;
    logic [14:0]           bg_hold_q, bg_hold_d;
    logic [7:0]            pix_x_q, pix_x_d;
    logic [6:0]            pix_y_q, pix_y_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  pix_spr_q, pix_spr_d;
    logic [6:0]            src_row;
    logic [14:0]           bg_addr;

    // Background address for the current screen pixel, wrapping the scrolled row.
    always_comb begin
        src_row = (cy_q >= scroll_q) ? (cy_q - scroll_q) : (cy_q + 7'(V_RES) - scroll_q);
        // Constant multiply reduces to (row<<7)+(row<<5) for a 160-wide screen.
        bg_addr = ({8'd0, src_row} * 15'(H_RES)) + {7'd0, cx_q};
    end

    // Next-state logic: sequencing, counters, latches and the pixel pipeline stage.
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        sx_d        = sx_q;
        sy_s_d      = sy_s_q;
        car_x_d     = car_x_q;
        car_y_d     = car_y_q;
        scroll_d    = scroll_q;
        bg_hold_d   = bg_hold_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = 1'b0;
        pix_spr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Tick) begin
                    state_d = StBg;
                    car_x_d = (CarX > XClamp) ? XClamp : CarX;
                    car_y_d = (CarY > YClamp) ? YClamp : CarY;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StBg: begin
                pix_valid_d = 1'b1;
                pix_x_d     = cx_q;
                pix_y_d     = cy_q;
                bg_hold_d   = bg_addr;
                if (cx_q == XLast) begin
                    cx_d = '0;
                    if (cy_q == YLast) begin
                        state_d = StCar;
                        sx_d    = '0;
                        sy_s_d  = '0;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            StCar: begin
                pix_valid_d = 1'b1;
                pix_spr_d   = 1'b1;
                pix_x_d     = car_x_q + 8'(sx_q);
                pix_y_d     = car_y_q + 7'(sy_s_q);
                // Counters stop at the last cell so SprAddr holds afterwards.
                if (sx_q == SprLast) begin
                    if (sy_s_q == SprLast) begin
                        state_d = StFlush;
                    end else begin
                        sx_d   = '0;
                        sy_s_d = sy_s_q + 1'b1;
                    end
                end else begin
                    sx_d = sx_q + 1'b1;
                end
            end
            StFlush: begin
                state_d = StIdle;
                if (ScrollEn) begin
                    scroll_d = (scroll_q == YLast) ? 7'd0 : scroll_q + 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            cx_q        <= '0;
            cy_q        <= '0;
            sx_q        <= '0;
            sy_s_q      <= '0;
            car_x_q     <= '0;
            car_y_q     <= '0;
            scroll_q    <= '0;
            bg_hold_q   <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_spr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            sx_q        <= sx_d;
            sy_s_q      <= sy_s_d;
            car_x_q     <= car_x_d;
            car_y_q     <= car_y_d;
            scroll_q    <= scroll_d;
            bg_hold_q   <= bg_hold_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            pix_spr_q   <= pix_spr_d;
        end
    end

    // Outputs: ROM data meets the registered pixel one cycle after its address.
    always_comb begin
        BgAddr    = (state_q == StBg) ? bg_addr : bg_hold_q;
        SprAddr   = {sy_s_q, sx_q};
        VgaX      = pix_x_q;
        VgaY      = pix_y_q;
        VgaColour = pix_valid_q ? (pix_spr_q ? SprData : BgData) : 3'd0;
        VgaPlot   = pix_valid_q && !(pix_spr_q && (SprData == TRANSPARENT));
        Busy      = (state_q != StIdle);
        FrameDone = (state_q == StFlush);
        Overrun   = Tick && (state_q != StIdle);
        ScrollY   = scroll_q;
    end

endmodule
